rvv_backend_uop_queue: RTL and testbench
========================================

Name: rvv_backend_uop_queue

Overview:
Multi-push / multi-pop circular FIFO between the decode unit and the dispatch stage of the RVV backend.
- Accepts up to NUM_PUSH decoded uops per cycle from the decoder.
- Presents up to NUM_POP oldest uops per cycle to dispatch, in program order.
- Generates the space-available backpressure that the decoder and command-queue control use to decide whether an instruction's next uop group may be issued.

Parameters:
- DEPTH, 16: number of uop entries; power of 2, >= NUM_PUSH+NUM_POP.
- NUM_PUSH, 4: push lanes; equals `NUM_DE_UOP.
- NUM_POP, 2: pop lanes to dispatch.
- DATA_WIDTH, $bits(UOP_QUEUE_t): width of one uop entry.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- flush  input  1  synchronous clear of all entries (trap/flush).
- uop_valid_de2uq  input  NUM_PUSH  per-lane push valid; must be contiguous from bit 0.
- uop_de2uq  input  NUM_PUSH*DATA_WIDTH  push data; lane i is the i-th uop in program order.
- uq_ready_uq2de  output  1  high when free entries >= NUM_PUSH.
- uop_valid_uq2dp  output  NUM_POP  lane i valid when occupancy > i.
- uop_uq2dp  output  NUM_POP*DATA_WIDTH  lane i = entry at rd_ptr+i (mod DEPTH).
- uop_ready_dp2uq  input  NUM_POP  per-lane pop acceptance; must be contiguous from bit 0.
- uq_empty  output  1  occupancy == 0.
- uq_free_cnt  output  $clog2(DEPTH)+1  DEPTH minus occupancy.

Behaviour:
State:
- wr_ptr, rd_ptr: $clog2(DEPTH) bits each, wrap modulo DEPTH.
- occ: $clog2(DEPTH)+1 bits.
- Entry array: DEPTH x DATA_WIDTH; no reset required on data.

Reset (rst_n low, asynchronous):
- wr_ptr=0, rd_ptr=0, occ=0.
- Outputs: uq_empty=1, uq_free_cnt=DEPTH, uq_ready_uq2de=1, uop_valid_uq2dp=0.
- uop_uq2dp is don't-care while not valid.
- Reset asserted mid-operation discards all contents immediately.

Push:
- push_cnt = popcount(uop_valid_de2uq & {NUM_PUSH{uq_ready_uq2de}}).
- Lane i is written to entry (wr_ptr+i) mod DEPTH.
- wr_ptr advances by push_cnt.
- Pushes while uq_ready_uq2de=0 are dropped; an assertion fires.

Pop:
- pop_cnt = popcount(uop_valid_uq2dp & uop_ready_dp2uq).
- rd_ptr advances by pop_cnt.
- Non-contiguous uop_ready_dp2uq or uop_valid_de2uq fires an assertion; the RTL does not need to repair it.

Occupancy:
- occ_next = occ + push_cnt - pop_cnt, updated in the same cycle; push and pop may coincide.
- uq_ready_uq2de, uq_free_cnt, uq_empty and uop_valid_uq2dp are all derived from registered occ only.
- There is no same-cycle pop credit for ready.
- There is no push-to-pop bypass: a uop pushed in cycle N is first visible on uop_uq2dp in cycle N+1.

Outputs:
- uop_uq2dp is read combinationally from the array at rd_ptr+i.
- Lanes stay stable while valid and not accepted.

Boundaries:
- Full (occ=DEPTH): ready=0, free_cnt=0; pops still allowed.
- occ in DEPTH-NUM_PUSH+1..DEPTH-1: ready=0 (e.g. occ 13..15 at defaults).
- Empty: uop_valid_uq2dp=0; uop_ready_dp2uq is ignored.
- occ=1: only lane 0 valid; lane 1 ready is ignored.
- Wrap-around: a 4-uop group starting at wr_ptr=14 writes entries 14, 15, 0, 1; pop lanes likewise wrap.

Flush:
- At the next edge: pointers=0, occ=0.
- Pushes and pops in the flush cycle are discarded.
- flush has priority over push and pop.

Assertions:
- occ never exceeds DEPTH.
- pop_cnt <= occ.
- DEPTH is a power of 2.

Test Plan:
- Reset, then 1 push (lane0 uop=0xA1), ready_dp=0 -> next cycle valid_uq2dp=01, uop lane0=0xA1, free_cnt=15, empty=0; not visible in the push cycle.
- 4 pushes x4 with ready_dp=0 -> occ 4/8/12/16; ready deasserts once occ=13..16 (after 4th group occ=16, free_cnt=0); a 5th push attempt is dropped and the assertion fires.
- From occ=12: push 4, pop 2 same cycle -> occ=14, ready=0 next cycle (push accepted since ready was computed on occ=12); outputs show the next 2 in-order uops.
- Wrap: advance pointers to 14, push uops 0x10..0x13 -> popping yields 0x10, 0x11 then 0x12, 0x13 in order; rd_ptr ends at 2.
- occ=1, ready_dp=11 -> only 1 uop popped, occ=0, empty=1, valid_uq2dp=00.
- occ=9 with simultaneous push 3 and pop 2, flush=1 -> occ=0, free_cnt=16, valid_uq2dp=00; async rst_n pulse mid-stream gives the same cleared state without a clock edge.

Source files
------------

// File: rtl/rvv_backend_uop_queue_if.sv
// rtl/rvv_backend_uop_queue_if.sv - decode/dispatch handshake bundle for the uop queue
interface rvv_backend_uop_queue_if #(
  parameter int NUM_PUSH   = 4,
  parameter int NUM_POP    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 5
);
  // decoder side
  logic [NUM_PUSH-1:0]            uop_valid_de2uq;
  logic [NUM_PUSH*DATA_WIDTH-1:0] uop_de2uq;
  logic                           uq_ready_uq2de;
  // dispatch side
  logic [NUM_POP-1:0]             uop_valid_uq2dp;
  logic [NUM_POP*DATA_WIDTH-1:0]  uop_uq2dp;
  logic [NUM_POP-1:0]             uop_ready_dp2uq;
  // status
  logic                           uq_empty;
  logic [CNT_W-1:0]               uq_free_cnt;

  // queue view
  modport slave (
    input  uop_valid_de2uq, uop_de2uq, uop_ready_dp2uq,
    output uq_ready_uq2de, uop_valid_uq2dp, uop_uq2dp, uq_empty, uq_free_cnt
  );

  // producer/consumer view
  modport master (
    output uop_valid_de2uq, uop_de2uq, uop_ready_dp2uq,
    input  uq_ready_uq2de, uop_valid_uq2dp, uop_uq2dp, uq_empty, uq_free_cnt
  );
endinterface

// File: rtl/rvv_backend_uop_queue.sv
// rtl/rvv_backend_uop_queue.sv - multi-push/multi-pop circular uop FIFO between decode and dispatch
module rvv_backend_uop_queue #(
  parameter int DEPTH      = 16,
  parameter int NUM_PUSH   = 4,
  parameter int NUM_POP    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  rvv_backend_uop_queue_if.slave  uq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]         free_cnt;
  logic                  ready;
  logic [NUM_PUSH-1:0]   push_en;
  logic [NUM_POP-1:0]    pop_valid;
  logic [NUM_POP-1:0]    pop_en;
  logic [CW-1:0]         push_cnt;
  logic [CW-1:0]         pop_cnt;

  // Backpressure comes from registered occupancy only; no same-cycle pop credit.
  assign free_cnt = CW'(DEPTH) - occ_q;
  assign ready    = (free_cnt >= CW'(NUM_PUSH));

  // Per-lane accept masks and their popcounts.
  always_comb begin
    push_en   = '0;
    pop_valid = '0;
    pop_en    = '0;
    push_cnt  = '0;
    pop_cnt   = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      push_en[i] = uq.uop_valid_de2uq[i] & ready;
      push_cnt   = push_cnt + CW'(push_en[i]);
    end
    for (int i = 0; i < NUM_POP; i++) begin
      pop_valid[i] = (occ_q > CW'(i));
      pop_en[i]    = pop_valid[i] & uq.uop_ready_dp2uq[i];
      pop_cnt      = pop_cnt + CW'(pop_en[i]);
    end
  end

  // Next pointers and occupancy; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_cnt);
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
    occ_d    = occ_q + push_cnt - pop_cnt;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage; lane i lands at wr_ptr+i, wrapping naturally on the PW-bit index.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < NUM_PUSH; i++) begin
        if (push_en[i]) begin
          mem_q[wr_ptr_q + PW'(i)] <= uq.uop_de2uq[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Oldest entries are read straight from the array, so there is no push-to-pop bypass.
  always_comb begin
    uq.uop_uq2dp = '0;
    for (int i = 0; i < NUM_POP; i++) begin
      uq.uop_uq2dp[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q + PW'(i)];
    end
  end

  assign uq.uop_valid_uq2dp = pop_valid;
  assign uq.uq_ready_uq2de  = ready;
  assign uq.uq_empty        = (occ_q == '0);
  assign uq.uq_free_cnt     = free_cnt;

  // Protocol and invariant checks; ignored by synthesis.
  always @(posedge clk) begin
    assert ((DEPTH & (DEPTH - 1)) == 0) else $error("uop queue DEPTH must be a power of 2");
    if (rst_n) begin
      assert (occ_q <= CW'(DEPTH)) else $error("uop queue occupancy exceeds DEPTH");
      assert (pop_cnt <= occ_q) else $error("uop queue pop count exceeds occupancy");
      assert (ready || (uq.uop_valid_de2uq == '0))
        else $error("uop queue push while not ready is dropped");
      assert ((uq.uop_valid_de2uq & (uq.uop_valid_de2uq + NUM_PUSH'(1))) == '0)
        else $error("uop queue push valid not contiguous");
      assert ((uq.uop_ready_dp2uq & (uq.uop_ready_dp2uq + NUM_POP'(1))) == '0)
        else $error("uop queue pop ready not contiguous");
    end
  end
endmodule

// File: tb/tb_rvv_backend_uop_queue.sv
// tb/tb_rvv_backend_uop_queue.sv - self-checking bench for the uop queue against a queue-based model
module tb_rvv_backend_uop_queue;
  localparam int DEPTH = 16;
  localparam int NUM_PUSH = 4;
  localparam int NUM_POP = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int n_asserts = 0;
  int n_fails = 0;

  logic [DW-1:0] model[$];
  logic [DW-1:0] lane_data[NUM_PUSH];

  rvv_backend_uop_queue_if #(.NUM_PUSH(NUM_PUSH), .NUM_POP(NUM_POP), .DATA_WIDTH(DW), .CNT_W(5)) uq_if ();

  rvv_backend_uop_queue #(.DEPTH(DEPTH), .NUM_PUSH(NUM_PUSH), .NUM_POP(NUM_POP), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .uq    (uq_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model contents.
  task automatic check_state(input string where);
    int sz;
    logic [1:0] exp_valid;
    sz = model.size();
    exp_valid = {(sz > 1), (sz > 0)};
    chk({where, ":ready"}, 64'(uq_if.uq_ready_uq2de), 64'((DEPTH - sz) >= NUM_PUSH));
    chk({where, ":empty"}, 64'(uq_if.uq_empty), 64'(sz == 0));
    chk({where, ":free"}, 64'(uq_if.uq_free_cnt), 64'(DEPTH - sz));
    chk({where, ":valid"}, 64'(uq_if.uop_valid_uq2dp), 64'(exp_valid));
    for (int i = 0; i < NUM_POP; i++) begin
      if (sz > i) chk($sformatf("%s:lane%0d", where, i), 64'(uq_if.uop_uq2dp[i*DW +: DW]), 64'(model[i]));
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_PUSH; i++) lane_data[i] = $urandom;
  endtask

  // One clock: drive, check before the edge, then advance the model.
  task automatic cycle(input int npush, input int npop, input bit fl, input string where);
    int sz;
    int pops;
    bit rdy;
    uq_if.uop_valid_de2uq = '0;
    uq_if.uop_ready_dp2uq = '0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (i < npush) uq_if.uop_valid_de2uq[i] = 1'b1;
      uq_if.uop_de2uq[i*DW +: DW] = lane_data[i];
    end
    for (int i = 0; i < NUM_POP; i++) begin
      if (i < npop) uq_if.uop_ready_dp2uq[i] = 1'b1;
    end
    flush = fl;
    #3;
    check_state(where);
    sz = model.size();
    rdy = ((DEPTH - sz) >= NUM_PUSH);
    pops = (npop < sz) ? npop : sz;
    @(posedge clk);
    #1;
    if (fl) begin
      model.delete();
    end else begin
      repeat (pops) void'(model.pop_front());
      if (rdy) for (int i = 0; i < npush; i++) model.push_back(lane_data[i]);
    end
    uq_if.uop_valid_de2uq = '0;
    uq_if.uop_ready_dp2uq = '0;
    flush = 1'b0;
  endtask

  initial begin
    int np;
    int npp;
    bit fl;
    rst_n = 1'b0;
    flush = 1'b0;
    uq_if.uop_valid_de2uq = '0;
    uq_if.uop_de2uq = '0;
    uq_if.uop_ready_dp2uq = '0;
    for (int i = 0; i < NUM_PUSH; i++) lane_data[i] = '0;
    #12;
    check_state("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single push, visible only next cycle
    lane_data[0] = 32'hA1;
    cycle(1, 0, 0, "push_a1");
    chk("a1_lane0", 64'(uq_if.uop_uq2dp[DW-1:0]), 64'h0000_00A1);
    chk("a1_valid", 64'(uq_if.uop_valid_uq2dp), 64'h1);
    chk("a1_free", 64'(uq_if.uq_free_cnt), 64'd15);

    // fill to full
    rand_data(); cycle(3, 0, 0, "fill4");
    rand_data(); cycle(4, 0, 0, "fill8");
    rand_data(); cycle(4, 0, 0, "fill12");
    rand_data(); cycle(4, 0, 0, "fill16");
    chk("full_ready", 64'(uq_if.uq_ready_uq2de), 64'h0);
    chk("full_free", 64'(uq_if.uq_free_cnt), 64'h0);

    // step occupancy down through the not-ready band
    cycle(0, 2, 0, "pop_to14");
    cycle(0, 1, 0, "pop_to13");
    chk("occ13_ready", 64'(uq_if.uq_ready_uq2de), 64'h0);
    cycle(0, 1, 0, "pop_to12");
    chk("occ12_ready", 64'(uq_if.uq_ready_uq2de), 64'h1);
    rand_data(); cycle(4, 2, 0, "push4_pop2");
    chk("occ14_ready", 64'(uq_if.uq_ready_uq2de), 64'h0);
    chk("occ14_free", 64'(uq_if.uq_free_cnt), 64'd2);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      rand_data();
      fl = ($urandom_range(0, 24) == 0);
      np = $urandom_range(0, NUM_PUSH);
      npp = $urandom_range(0, NUM_POP);
      if ((DEPTH - model.size()) < NUM_PUSH) np = 0;
      cycle(np, npp, fl, "rand");
    end

    // wrap-around: park both pointers at 14
    cycle(0, 0, 1, "wrap_flush");
    rand_data(); cycle(2, 0, 0, "wrap_adv");
    for (int n = 0; n < 6; n++) begin
      rand_data(); cycle(2, 2, 0, "wrap_adv");
    end
    cycle(0, 2, 0, "wrap_drain");
    chk("wrap_empty", 64'(uq_if.uq_empty), 64'h1);
    for (int i = 0; i < NUM_PUSH; i++) lane_data[i] = 32'h10 + 32'(i);
    cycle(4, 0, 0, "wrap_push");
    chk("wrap_l0", 64'(uq_if.uop_uq2dp[DW-1:0]), 64'h10);
    chk("wrap_l1", 64'(uq_if.uop_uq2dp[2*DW-1:DW]), 64'h11);
    cycle(0, 2, 0, "wrap_pop1");
    chk("wrap_l2", 64'(uq_if.uop_uq2dp[DW-1:0]), 64'h12);
    chk("wrap_l3", 64'(uq_if.uop_uq2dp[2*DW-1:DW]), 64'h13);
    cycle(0, 2, 0, "wrap_pop2");
    rand_data(); cycle(3, 0, 0, "wrap_next");
    cycle(0, 2, 0, "wrap_next_pop");
    cycle(0, 1, 0, "wrap_next_pop");

    // occ=1 with both ready lanes set
    rand_data(); cycle(1, 0, 0, "occ1_push");
    cycle(0, 2, 0, "occ1_pop");
    chk("occ1_empty", 64'(uq_if.uq_empty), 64'h1);
    chk("occ1_valid", 64'(uq_if.uop_valid_uq2dp), 64'h0);

    // flush with simultaneous push and pop at occ=9
    rand_data(); cycle(4, 0, 0, "f_build");
    rand_data(); cycle(4, 0, 0, "f_build");
    rand_data(); cycle(1, 0, 0, "f_build");
    chk("f_free9", 64'(uq_if.uq_free_cnt), 64'd7);
    rand_data(); cycle(3, 2, 1, "f_flush");
    chk("f_free", 64'(uq_if.uq_free_cnt), 64'd16);
    chk("f_valid", 64'(uq_if.uop_valid_uq2dp), 64'h0);
    cycle(0, 0, 0, "f_idle");

    // asynchronous reset mid-stream, checked before any clock edge
    rand_data(); cycle(4, 0, 0, "ar_build");
    rand_data(); cycle(4, 1, 0, "ar_build");
    #2;
    rst_n = 1'b0;
    #1;
    model.delete();
    check_state("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_data(); cycle(2, 0, 0, "post_rst");
    cycle(0, 2, 0, "post_rst");
    cycle(0, 0, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
